mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 92 +++++++++
 tb/tb_mem_stage.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: pipeline memory stage, aligns/extends load data and forwards results to writeback
module mem_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        ws_allowin,
  output logic        ms_allowin,
  input  logic        es_to_ms_valid,
  input  logic [81:0] es_to_ms_bus,
  input  logic [31:0] data_sram_rdata,
  output logic        ms_to_ws_valid,
  output logic [72:0] ms_to_ws_bus,
  output logic [5:0]  stall_ms_bus,
  output logic [32:0] forward_ms_bus
);
  logic        ms_valid;
  logic        ms_first;
  logic [81:0] ms_bus;
  logic [31:0] hold;
  logic        accept;
  logic        res_from_mem;
  logic [6:0]  ld;
  logic [4:0]  dest;
  logic [31:0] alu_result;
  logic [31:0] pc;
  logic [1:0]  a;
  logic [31:0] w;
  logic [31:0] shr;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic        onehot;
  logic [31:0] ld_res;
  logic [3:0]  ld_strb;
  logic [31:0] ms_final_result;
  logic [3:0]  rf_strb;

  assign accept         = es_to_ms_valid && ms_allowin;
  assign ms_allowin     = !ms_valid || ws_allowin;
  assign ms_to_ws_valid = ms_valid;
  assign {res_from_mem, ld} = ms_bus[81:74];
  assign dest           = ms_bus[68:64];
  assign alu_result     = ms_bus[63:32];
  assign pc             = ms_bus[31:0];
  assign a              = alu_result[1:0];

  // valid bit and first-cycle flag; sram data is only live the cycle after acceptance
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ms_valid <= 1'b0;
      ms_first <= 1'b0;
    end else begin
      if (ms_allowin) ms_valid <= es_to_ms_valid;
      ms_first <= accept;
    end
  end

  // instruction payload register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ms_bus <= '0;
    else if (accept) ms_bus <= es_to_ms_bus;
  end

  // keep sram data alive when writeback stalls during the first cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) hold <= '0;
    else if (ms_first && ms_valid && !ws_allowin) hold <= data_sram_rdata;
  end

  // load alignment, extension and register write strobes
  always_comb begin
    w       = ms_first ? data_sram_rdata : hold;
    shr     = w >> {a, 3'b000};
    byte_v  = shr[7:0];
    half_v  = a[1] ? w[31:16] : w[15:0];
    onehot  = (ld != 7'd0) && ((ld & (ld - 7'd1)) == 7'd0);
    ld_res  = !onehot ? w :
              ld[6]   ? {{24{byte_v[7]}}, byte_v} :
              ld[5]   ? {24'd0, byte_v} :
              ld[4]   ? {{16{half_v[15]}}, half_v} :
              ld[3]   ? {16'd0, half_v} :
              ld[1]   ? w << {~a, 3'b000} :
              ld[0]   ? shr : w;
    ld_strb = !onehot ? 4'hf :
              ld[1]   ? 4'hf << ~a :
              ld[0]   ? 4'hf >> a : 4'hf;
    ms_final_result = res_from_mem ? ld_res : alu_result;
    rf_strb         = res_from_mem ? ld_strb : 4'hf;
  end

  assign ms_to_ws_bus   = {rf_strb, dest, ms_final_result, pc};
  assign stall_ms_bus   = {ms_valid && (dest != 5'd0), dest};
  assign forward_ms_bus = {ms_valid && (rf_strb == 4'hf), ms_final_result};
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: scoreboard bench for mem_stage load alignment, stalls and reset
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic        ws_allowin;
  logic        ms_allowin;
  logic        es_to_ms_valid;
  logic [81:0] es_to_ms_bus;
  logic [31:0] data_sram_rdata;
  logic        ms_to_ws_valid;
  logic [72:0] ms_to_ws_bus;
  logic [5:0]  stall_ms_bus;
  logic [32:0] forward_ms_bus;

  localparam logic [6:0] LB = 7'b1000000, LBU = 7'b0100000, LH = 7'b0010000, LHU = 7'b0001000;
  localparam logic [6:0] LW = 7'b0000100, LWL = 7'b0000010, LWR = 7'b0000001, NONE = 7'b0000000;

  int vectors = 0;
  int errors = 0;
  int pops = 0;
  int p0;
  logic [31:0] next_rd = 32'h0;
  logic [31:0] pc = 32'hbfc0_0000;
  logic [72:0] sb[$];

  mem_stage dut (
    .clk(clk), .reset(reset), .ws_allowin(ws_allowin), .ms_allowin(ms_allowin),
    .es_to_ms_valid(es_to_ms_valid), .es_to_ms_bus(es_to_ms_bus),
    .data_sram_rdata(data_sram_rdata), .ms_to_ws_valid(ms_to_ws_valid),
    .ms_to_ws_bus(ms_to_ws_bus), .stall_ms_bus(stall_ms_bus), .forward_ms_bus(forward_ms_bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [72:0] model(input logic [81:0] b, input logic [31:0] rd);
    logic [31:0] alu, r;
    logic [1:0]  a;
    logic [3:0]  s;
    alu = b[63:32];
    a   = alu[1:0];
    r   = rd;
    s   = 4'hf;
    if (!b[81]) r = alu;
    else case (b[80:74])
      LB:  r = {{24{rd[8*a+7]}}, rd[8*a +: 8]};
      LBU: r = {24'd0, rd[8*a +: 8]};
      LH:  r = {{16{rd[16*a[1]+15]}}, rd[16*a[1] +: 16]};
      LHU: r = {16'd0, rd[16*a[1] +: 16]};
      LWL: case (a)
        2'd0: begin r = {rd[7:0], 24'd0};  s = 4'b1000; end
        2'd1: begin r = {rd[15:0], 16'd0}; s = 4'b1100; end
        2'd2: begin r = {rd[23:0], 8'd0};  s = 4'b1110; end
        default: begin r = rd; s = 4'b1111; end
      endcase
      LWR: case (a)
        2'd0: begin r = rd; s = 4'b1111; end
        2'd1: begin r = {8'd0, rd[31:8]};  s = 4'b0111; end
        2'd2: begin r = {16'd0, rd[31:16]}; s = 4'b0011; end
        default: begin r = {24'd0, rd[31:24]}; s = 4'b0001; end
      endcase
      default: r = rd;
    endcase
    return {s, b[68:64], r, b[31:0]};
  endfunction

  function automatic logic [81:0] mk(input logic rfm, input logic [6:0] ld, input logic [4:0] dest, input logic [31:0] alu);
    return {rfm, ld, 5'h15, dest, alu, 32'h0};
  endfunction

  task automatic send(input logic [81:0] b, input logic [31:0] rd);
    b[31:0] = pc;
    pc += 4;
    data_sram_rdata = next_rd;
    es_to_ms_valid  = 1'b1;
    es_to_ms_bus    = b;
    sb.push_back(model(b, rd));
    next_rd = rd;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    data_sram_rdata = next_rd;
    next_rd = $urandom;
    es_to_ms_valid = 1'b0;
    es_to_ms_bus = {$urandom, $urandom, $urandom};
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!reset && ms_to_ws_valid && ws_allowin) begin
      check("sb_nonempty", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        logic [72:0] e;
        e = sb.pop_front();
        check("result", ms_to_ws_bus[63:32], e[63:32]);
        check("strb", ms_to_ws_bus[72:69], e[72:69]);
        check("dest", ms_to_ws_bus[68:64], e[68:64]);
        check("pc", ms_to_ws_bus[31:0], e[31:0]);
        check("fwd_valid", forward_ms_bus[32], e[72:69] == 4'hf);
        check("fwd_data", forward_ms_bus[31:0], e[63:32]);
        check("stall_valid", stall_ms_bus[5], e[68:64] != 5'd0);
        pops++;
      end
    end
  end

  initial begin
    reset = 1'b1;
    ws_allowin = 1'b1;
    es_to_ms_valid = 1'b0;
    es_to_ms_bus = '0;
    data_sram_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", ms_to_ws_valid, 0);
    check("rst_allowin", ms_allowin, 1);
    check("rst_stall_v", stall_ms_bus[5], 0);
    check("rst_fwd_v", forward_ms_bus[32], 0);
    check("rst_bus", ms_to_ws_bus[63:0], 0);
    reset = 1'b0;
    send(mk(1, LB,  5'd3, 32'h1001), 32'h1280_3456);
    send(mk(1, LB,  5'd4, 32'h1002), 32'h1280_3456);
    send(mk(1, LBU, 5'd5, 32'h1002), 32'h1280_3456);
    send(mk(1, LHU, 5'd6, 32'h2002), 32'hbeef_1234);
    send(mk(1, LH,  5'd7, 32'h2002), 32'hbeef_1234);
    send(mk(1, LH,  5'd7, 32'h2000), 32'h1234_8765);
    for (int i = 0; i < 4; i++) send(mk(1, LWL, 5'd8, 32'h3000 + i), 32'haabb_ccdd);
    for (int i = 0; i < 4; i++) send(mk(1, LWR, 5'd9, 32'h3000 + i), 32'haabb_ccdd);
    send(mk(1, LW,   5'd10, 32'h4000), 32'hcafe_f00d);
    send(mk(1, 7'b1100000, 5'd11, 32'h4001), 32'h0102_0304);
    send(mk(1, NONE, 5'd12, 32'h4002), 32'h0506_0708);
    send(mk(1, LBU,  5'd0,  32'h4003), 32'h9abc_def0);
    idle();
    p0 = pops;
    for (int i = 1; i <= 3; i++) send(mk(0, LW, 5'd13, i), $urandom);
    idle();
    check("no_bubble", pops - p0, 3);
    idle();
    send(mk(1, LW, 5'd14, 32'h100), 32'h1122_3344);
    ws_allowin = 1'b0;
    data_sram_rdata = 32'h1122_3344;
    es_to_ms_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_allowin", ms_allowin, 0);
      check("stall_hold", ms_to_ws_bus[63:32], 32'h1122_3344);
      @(posedge clk);
      #1;
      data_sram_rdata = 32'hdead_beef;
    end
    ws_allowin = 1'b1;
    @(posedge clk);
    #1;
    check("stall_drained", sb.size(), 0);
    send(mk(1, LW, 5'd15, 32'h200), 32'h5566_7788);
    ws_allowin = 1'b0;
    data_sram_rdata = 32'h5566_7788;
    es_to_ms_valid = 1'b0;
    @(posedge clk);
    #1;
    data_sram_rdata = 32'hdead_beef;
    #2;
    reset = 1'b1;
    #1;
    check("rst_mid_valid", ms_to_ws_valid, 0);
    check("rst_mid_allowin", ms_allowin, 1);
    check("rst_mid_stall_v", stall_ms_bus[5], 0);
    check("rst_mid_fwd_v", forward_ms_bus[32], 0);
    check("rst_mid_bus", ms_to_ws_bus[63:32], 0);
    sb.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    ws_allowin = 1'b1;
    send(mk(1, LBU, 5'd16, 32'h303), 32'hc300_0000);
    idle();
    idle();
    check("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
